mem_req_ctrl: RTL and testbench

Clocked initiator for the byte-addressed 512x8 data memory's MOV/MOC handshake. It accepts one load/store request at a time from the control unit and checks alignment, opcode and range. It then drives MAR/Op3/write data, raises MOV, waits for MOC, captures read data, and returns a single-cycle response with an error code. It sits between the CU datapath and the memory, and is the only block that drives MOV.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/mem_req_ctrl_if.sv | 28 ++
 rtl/moc_sync.sv | 20 ++
 rtl/mem_req_ctrl.sv | 72 +++++++
 tb/tb_mem_req_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared opcodes, error codes, access-size decode and FSM states for the memory request path.
//   Contents: op3 constants, ERR_* codes, size_e, state_e,
//             access_size(), is_load(), check_req().
package mem_pkg;
    localparam logic [5:0] OP_LDSB = 6'b001001;
    localparam logic [5:0] OP_LDSH = 6'b001010;
    localparam logic [5:0] OP_LD   = 6'b000000;
    localparam logic [5:0] OP_LDUB = 6'b000001;
    localparam logic [5:0] OP_LDUH = 6'b000010;
    localparam logic [5:0] OP_STB  = 6'b000101;
    localparam logic [5:0] OP_STH  = 6'b000110;
    localparam logic [5:0] OP_ST   = 6'b000100;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ALIGN   = 2'b01;
    localparam logic [1:0] ERR_BAD     = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_NONE} size_e;
    typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, RESP, ERR} state_e;

    function automatic size_e access_size(input logic [5:0] op3);
        return (op3 inside {OP_LDSB, OP_LDUB, OP_STB}) ? SZ_BYTE :
               (op3 inside {OP_LDSH, OP_LDUH, OP_STH}) ? SZ_HALF :
               (op3 inside {OP_LD, OP_ST})             ? SZ_WORD : SZ_NONE;
    endfunction

    function automatic logic is_load(input logic [5:0] op3);
        return op3 inside {OP_LDSB, OP_LDSH, OP_LD, OP_LDUB, OP_LDUH};
    endfunction

    // Opcode/range failure outranks misalignment.
    function automatic logic [1:0] check_req(input logic [5:0] op3, input logic [22:0] hi,
                                             input logic [1:0] lo);
        size_e sz = access_size(op3);
        if (sz == SZ_NONE || |hi)
            return ERR_BAD;
        if ((sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && |lo))
            return ERR_ALIGN;
        return ERR_OK;
    endfunction
endpackage

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: CU request/response bus plus the MOV/MOC memory handshake.
//   master: the controller (drives req_ready, rsp_*, MOV, MAR, Op3, mem_wdata).
//   slave:  CU and memory side (drives req_*, MOC, mem_rdata).
interface mem_req_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        MOV;
    logic [31:0] MAR;
    logic [5:0]  Op3;
    logic [31:0] mem_wdata;
    logic        MOC;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_op3, req_addr, req_wdata, MOC, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, MOV, MAR, Op3, mem_wdata
    );
    modport slave (
        output req_valid, req_op3, req_addr, req_wdata, MOC, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, MOV, MAR, Op3, mem_wdata
    );
endinterface

// File: rtl/moc_sync.sv
// moc_sync: two-flop synchronizer for the asynchronous MOC plus rising-edge detect.
//   clk, reset_n (async active-low), moc in; moc_rise out (one cycle per MOC rising edge).
module moc_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic moc,
    output logic moc_rise
);
    logic [2:0] sh;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sh <= '0;
        else
            sh <= {sh[1:0], moc};
    end

    // sh[1] is the synchronized MOC; sh[2] is its previous value.
    assign moc_rise = sh[1] & ~sh[2];
endmodule

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding load/store initiator for the 512x8 memory MOV/MOC handshake.
//   clk, reset_n (async active-low); bus (master): CU request/response and memory MOV/MAR/Op3/
//   mem_wdata/MOC/mem_rdata. TIMEOUT = cycles MOV may stay high without MOC.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input logic            clk,
    input logic            reset_n,
    mem_req_ctrl_if.master bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    state_e        state, nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    chk, err_q;
    logic          moc_rise, accept, done;

    moc_sync u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .moc      (bus.MOC),
        .moc_rise (moc_rise)
    );

    assign chk           = check_req(bus.req_op3, bus.req_addr[31:9], bus.req_addr[1:0]);
    assign accept        = bus.req_valid && state == IDLE;
    // Completion and timeout on the same cycle both land here; moc_rise decides the code.
    assign done          = state == ACTIVE && (moc_rise || cnt == CW'(TIMEOUT - 1));
    assign bus.req_ready = state == IDLE;
    assign bus.MOV       = state == ACTIVE;

    always_comb begin
        nxt = state;
        nxt = state == IDLE   ? (bus.req_valid ? (chk == ERR_OK ? SETUP : ERR) : IDLE) :
              state == SETUP  ? ACTIVE :
              state == ACTIVE ? (done ? RESP : ACTIVE) : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            err_q         <= ERR_OK;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= ERR_OK;
            bus.MAR       <= '0;
            bus.Op3       <= '0;
            bus.mem_wdata <= '0;
        end else begin
            state         <= nxt;
            cnt           <= state == ACTIVE ? cnt + CW'(1) : '0;
            bus.rsp_valid <= state == ERR || done;
            // Memory-facing fields hold until the next accept so memory data stays valid after MOC.
            if (accept) begin
                bus.MAR       <= bus.req_addr;
                bus.Op3       <= bus.req_op3;
                bus.mem_wdata <= bus.req_wdata;
                err_q         <= chk;
            end
            if (state == ERR) begin
                bus.rsp_err   <= err_q;
                bus.rsp_rdata <= '0;
            end else if (done) begin
                bus.rsp_err   <= moc_rise ? ERR_OK : ERR_TIMEOUT;
                bus.rsp_rdata <= moc_rise && is_load(bus.Op3) ? bus.mem_rdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: randomized self-checking bench with a byte-array memory model and reference model.
module tb_mem_req_ctrl;
    localparam logic [5:0] LDSB = 6'b001001, LDSH = 6'b001010, LD = 6'b000000, LDUB = 6'b000001;
    localparam logic [5:0] LDUH = 6'b000010, STB = 6'b000101, STH = 6'b000110, ST = 6'b000100;

    logic clk = 0, reset_n = 0;
    logic moc_mem = 0, moc_stray = 0;
    int   cyc = 0, total = 0, bad = 0;
    int   dead = 0, force_dly = -1, mem_ops = 0, moc_cyc = -1;
    logic [7:0] mem [512];
    logic [7:0] rmem [512];
    logic [5:0] ops [8] = '{LDSB, LDSH, LD, LDUB, LDUH, STB, STH, ST};

    int          r_acc, r_rsp, r_mov_at, r_movc, r_rises, r_moc;
    logic [31:0] r_rd, r_mar, r_wd;
    logic [5:0]  r_op;
    logic [1:0]  r_er;

    mem_req_ctrl_if bus();
    assign bus.MOC = moc_mem | moc_stray;

    mem_req_ctrl #(.TIMEOUT(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int size_of(input logic [5:0] op);
        return (op == LDSB || op == LDUB || op == STB) ? 1 :
               (op == LDSH || op == LDUH || op == STH) ? 2 : (op == LD || op == ST) ? 4 : 0;
    endfunction

    function automatic bit is_ld(input logic [5:0] op);
        return op == LDSB || op == LDSH || op == LD || op == LDUB || op == LDUH;
    endfunction

    function automatic logic [1:0] exp_err(input logic [5:0] op, input logic [31:0] a);
        int sz = size_of(op);
        if (sz == 0 || a > 511) return 2'b10;
        if (a % sz != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input int a);
        int sz = size_of(op);
        longint v = 0;
        for (int i = 0; i < sz; i++) v = v * 256 + rmem[a + i];
        if ((op == LDSB || op == LDSH) && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
        return v[31:0];
    endfunction

    function automatic void exp_store(input logic [5:0] op, input int a, input logic [31:0] d);
        int sz = size_of(op);
        for (int i = 0; i < sz; i++) rmem[a + i] = 8'((d >> (8 * (sz - 1 - i))) & 32'hff);
    endfunction

    function automatic logic [31:0] mem_read(input logic [5:0] op, input logic [8:0] a);
        logic [7:0]  b = mem[a];
        logic [15:0] h = {mem[a], mem[9'(a + 9'd1)]};
        logic [31:0] w = {mem[a], mem[9'(a + 9'd1)], mem[9'(a + 9'd2)], mem[9'(a + 9'd3)]};
        return op == LDSB ? 32'($signed(b)) : op == LDUB ? {24'h0, b} :
               op == LDSH ? 32'($signed(h)) : op == LDUH ? {16'h0, h} : op == LD ? w : 32'h0;
    endfunction

    // Memory model: answers each MOV rising edge after a random (or forced) delay.
    initial begin
        logic [8:0] a;
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        {mem[16], mem[17], mem[18], mem[19]} = 32'hDEADBEEF;
        mem[33] = 8'h80;
        bus.mem_rdata = '0;
        forever begin
            @(posedge bus.MOV);
            if (dead == 0) begin
                repeat (force_dly >= 0 ? force_dly : int'($urandom_range(0, 5))) @(posedge clk);
                #($urandom_range(2, 7));
                moc_cyc = cyc;
                a = bus.MAR[8:0];
                bus.mem_rdata = mem_read(bus.Op3, a);
                if (bus.Op3 == STB) mem[a] = bus.mem_wdata[7:0];
                if (bus.Op3 == STH) {mem[a], mem[9'(a + 9'd1)]} = bus.mem_wdata[15:0];
                if (bus.Op3 == ST) {mem[a], mem[9'(a + 9'd1)], mem[9'(a + 9'd2)], mem[9'(a + 9'd3)]} = bus.mem_wdata;
                mem_ops++;
                moc_mem = 1;
                repeat (2) @(posedge clk);
                wait (!bus.MOV);
                #2 moc_mem = 0;
            end
        end
    end

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        int n0 = mem_ops;
        bit prev = 0;
        @(negedge clk);
        bus.req_op3 = op; bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1;
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        @(posedge clk); #1;
        bus.req_valid = 0;
        r_acc = cyc; r_rsp = -1; r_mov_at = -1; r_movc = 0; r_rises = 0; r_rd = 'x; r_er = 'x;
        for (int i = 0; i < 60 && r_rsp < 0; i++) begin
            @(posedge clk); #1;
            if (bus.MOV) begin
                r_movc++;
                if (!prev) begin
                    r_rises++;
                    if (r_mov_at < 0) begin r_mov_at = cyc; r_mar = bus.MAR; r_op = bus.Op3; r_wd = bus.mem_wdata; end
                end
            end
            prev = bus.MOV;
            if (bus.rsp_valid) begin r_rsp = cyc; r_rd = bus.rsp_rdata; r_er = bus.rsp_err; end
        end
        r_moc = mem_ops == n0 + 1 ? moc_cyc : -1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
        total++; if (bus.rsp_err !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", bus.rsp_err); end
        total++; if (bus.MOV !== 1'b0) begin bad++; $display("FAIL reset_mov got=%b exp=0", bus.MOV); end
        total++; if (bus.MAR !== 32'h0) begin bad++; $display("FAIL reset_mar got=%h exp=0", bus.MAR); end
        total++; if (bus.Op3 !== 6'h0) begin bad++; $display("FAIL reset_op3 got=%b exp=0", bus.Op3); end
        total++; if (bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.mem_wdata); end
        @(negedge clk); reset_n = 1;
    endtask

    task automatic test_word_load;
        issue(LD, 32'h10, 32'h0);
        total++; if (r_rsp < 0) begin bad++; $display("FAIL wl_rsp_seen got=none exp=rsp"); end
        total++; if (r_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL wl_rdata got=%h exp=deadbeef", r_rd); end
        total++; if (r_er !== 2'b00) begin bad++; $display("FAIL wl_err got=%b exp=00", r_er); end
        total++; if (r_rises !== 1) begin bad++; $display("FAIL wl_mov_pulses got=%0d exp=1", r_rises); end
        total++; if (r_mar !== 32'h10 || r_op !== LD) begin bad++; $display("FAIL wl_mar_op3 got=%h/%b exp=10/000000", r_mar, r_op); end
        total++; if (r_mov_at != r_acc + 1) begin bad++; $display("FAIL wl_mov_rise got=%0d exp=%0d", r_mov_at, r_acc + 1); end
        total++; if (r_moc < 0 || r_rsp != r_moc + 3) begin bad++; $display("FAIL wl_rsp_latency got=%0d exp=%0d", r_rsp, r_moc + 3); end
    endtask

    task automatic test_signed_byte;
        issue(LDSB, 32'h21, 32'h0);
        total++; if (r_rd !== 32'hFFFFFF80 || r_er !== 2'b00) begin bad++; $display("FAIL sb_ldsb got=%h/%b exp=ffffff80/00", r_rd, r_er); end
        issue(ST, 32'h40, 32'h12345678);
        exp_store(ST, 32'h40, 32'h12345678);
        total++; if (r_rd !== 32'h0 || r_er !== 2'b00) begin bad++; $display("FAIL sb_st_rsp got=%h/%b exp=0/00", r_rd, r_er); end
        total++; if (r_wd !== 32'h12345678 || r_rises !== 1) begin bad++; $display("FAIL sb_st_wdata got=%h/%0d exp=12345678/1", r_wd, r_rises); end
        issue(LD, 32'h40, 32'h0);
        total++; if (r_rd !== 32'h12345678) begin bad++; $display("FAIL sb_ld_back got=%h exp=12345678", r_rd); end
        total++; if (r_rd !== exp_load(LD, 32'h40)) begin bad++; $display("FAIL sb_ld_model got=%h exp=%h", r_rd, exp_load(LD, 32'h40)); end
    endtask

    task automatic test_errors;
        logic [5:0]  t_op [3] = '{STH, 6'b000011, LD};
        logic [31:0] t_a  [3] = '{32'h41, 32'h0, 32'h200};
        logic [1:0]  t_e  [3] = '{2'b01, 2'b10, 2'b10};
        for (int i = 0; i < 3; i++) begin
            issue(t_op[i], t_a[i], 32'hA5A5A5A5);
            total++; if (r_er !== t_e[i]) begin bad++; $display("FAIL err%0d_code got=%b exp=%b", i, r_er, t_e[i]); end
            total++; if (r_rises !== 0) begin bad++; $display("FAIL err%0d_mov got=%0d exp=0", i, r_rises); end
            total++; if (r_rsp != r_acc + 1) begin bad++; $display("FAIL err%0d_latency got=%0d exp=%0d", i, r_rsp, r_acc + 1); end
            total++; if (r_rd !== 32'h0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, r_rd); end
        end
    endtask

    task automatic test_timeout;
        int nr = 0, nm = 0;
        dead = 1;
        issue(LD, 32'h10, 32'h0);
        total++; if (r_er !== 2'b11 || r_rd !== 32'h0) begin bad++; $display("FAIL to_rsp got=%b/%h exp=11/0", r_er, r_rd); end
        total++; if (r_movc !== 16) begin bad++; $display("FAIL to_mov_cycles got=%0d exp=16", r_movc); end
        total++; if (r_rsp != r_mov_at + 16) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", r_rsp, r_mov_at + 16); end
        @(negedge clk); moc_stray = 1;
        repeat (3) @(negedge clk); moc_stray = 0;
        repeat (10) begin @(posedge clk); #1; nr += int'(bus.rsp_valid); nm += int'(bus.MOV); end
        total++; if (nr != 0 || nm != 0) begin bad++; $display("FAIL to_stray got=rsp%0d/mov%0d exp=0/0", nr, nm); end
        total++; if (bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_stray_rdata got=%h exp=0", bus.rsp_rdata); end
        dead = 0;
    endtask

    task automatic test_timeout_boundary;
        int nr = 0;
        force_dly = 13;
        issue(LD, 32'h10, 32'h0);
        total++; if (r_er !== 2'b00 || r_rd !== 32'hDEADBEEF) begin bad++; $display("FAIL tb_last_cycle got=%b/%h exp=00/deadbeef", r_er, r_rd); end
        total++; if (r_movc !== 16 || r_rsp != r_moc + 3) begin bad++; $display("FAIL tb_last_timing got=%0d/%0d exp=16/%0d", r_movc, r_rsp, r_moc + 3); end
        force_dly = 14;
        issue(LD, 32'h10, 32'h0);
        total++; if (r_er !== 2'b11 || r_rd !== 32'h0) begin bad++; $display("FAIL tb_late got=%b/%h exp=11/0", r_er, r_rd); end
        repeat (8) begin @(posedge clk); #1; nr += int'(bus.rsp_valid); end
        total++; if (nr != 0 || bus.rsp_rdata !== 32'h0) begin bad++; $display("FAIL tb_late_ignored got=%0d/%h exp=0/0", nr, bus.rsp_rdata); end
        force_dly = -1;
    endtask

    task automatic test_reset_mid;
        int nr = 0;
        dead = 1;
        @(negedge clk);
        bus.req_op3 = LD; bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_valid = 1;
        @(posedge clk); #1 bus.req_valid = 0;
        repeat (4) @(posedge clk); #1;
        total++; if (bus.MOV !== 1'b1) begin bad++; $display("FAIL rm_active got=%b exp=1", bus.MOV); end
        #2 reset_n = 0;
        #1;
        total++; if (bus.MOV !== 1'b0) begin bad++; $display("FAIL rm_mov got=%b exp=0", bus.MOV); end
        total++; if (bus.MAR !== 32'h0 || bus.Op3 !== 6'h0 || bus.mem_wdata !== 32'h0) begin bad++; $display("FAIL rm_bus got=%h/%b/%h exp=0/0/0", bus.MAR, bus.Op3, bus.mem_wdata); end
        total++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 2'b00 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_rsp got=%b/%b/%b exp=0/00/1", bus.rsp_valid, bus.rsp_err, bus.req_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1;
        repeat (10) begin @(posedge clk); #1; nr += int'(bus.rsp_valid); end
        total++; if (nr != 0 || bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_after got=%0d/%b exp=0/1", nr, bus.req_ready); end
        dead = 0;
        issue(LD, 32'h10, 32'h0);
        total++; if (r_rd !== 32'hDEADBEEF || r_er !== 2'b00) begin bad++; $display("FAIL rm_reload got=%h/%b exp=deadbeef/00", r_rd, r_er); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ad [3] = '{32'h10, 32'h40, 32'h20};
        int acc [3], rc [3];
        logic [31:0] rdv [3];
        logic [1:0]  erv [3];
        int idx = 0, nr = 0, rises = 0, low = 100, min_gap = 100;
        bit rdy, prev = 0;
        @(negedge clk);
        bus.req_op3 = LD; bus.req_addr = ad[0]; bus.req_wdata = 0; bus.req_valid = 1;
        for (int c = 0; c < 300 && nr < 3; c++) begin
            @(negedge clk); rdy = bus.req_ready;
            @(posedge clk); #1;
            if (rdy && bus.req_valid) begin
                acc[idx] = cyc; idx++;
                if (idx < 3) bus.req_addr = ad[idx]; else bus.req_valid = 0;
            end
            if (bus.MOV && !prev) begin rises++; if (rises > 1 && low < min_gap) min_gap = low; end
            low = bus.MOV ? 0 : low + 1;
            prev = bus.MOV;
            if (bus.rsp_valid && nr < 3) begin rc[nr] = cyc; rdv[nr] = bus.rsp_rdata; erv[nr] = bus.rsp_err; nr++; end
        end
        bus.req_valid = 0;
        total++; if (nr != 3 || idx != 3 || rises != 3) begin bad++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=3/3/3", nr, idx, rises); end
        total++; if (min_gap < 2) begin bad++; $display("FAIL b2b_mov_gap got=%0d exp>=2", min_gap); end
        for (int i = 0; i < nr; i++) begin
            total++; if (rdv[i] !== exp_load(LD, ad[i]) || erv[i] !== 2'b00) begin bad++; $display("FAIL b2b_rsp%0d got=%h/%b exp=%h/00", i, rdv[i], erv[i], exp_load(LD, ad[i])); end
            if (i > 0) begin
                total++; if (acc[i] <= rc[i-1]) begin bad++; $display("FAIL b2b_accept%0d got=%0d exp>%0d", i, acc[i], rc[i-1]); end
            end
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 40; n++) begin
            int k = $urandom_range(0, 9), m = $urandom_range(0, 9), sz;
            logic [5:0]  op = k < 8 ? ops[k] : (k == 8 ? 6'b000011 : 6'($urandom));
            logic [31:0] a, d = $urandom, ed;
            logic [1:0]  ee;
            sz = size_of(op);
            a = m == 0 ? $urandom : 32'($urandom_range(0, 511));
            if (m > 0 && m < 7 && sz > 0) a = a - a % sz;
            ee = exp_err(op, a);
            ed = (ee == 0 && is_ld(op)) ? exp_load(op, a) : 32'h0;
            issue(op, a, d);
            if (ee == 0 && !is_ld(op)) exp_store(op, a, d);
            total++; if (r_er !== ee || r_rd !== ed) begin bad++; $display("FAIL rnd%0d op=%b a=%h got=%b/%h exp=%b/%h", n, op, a, r_er, r_rd, ee, ed); end
            total++; if (r_rises != int'(ee == 0)) begin bad++; $display("FAIL rnd%0d_mov got=%0d exp=%0d", n, r_rises, int'(ee == 0)); end
            if (ee == 0) begin
                total++; if (r_mar !== a || r_op !== op || r_rsp != r_moc + 3) begin bad++; $display("FAIL rnd%0d_bus got=%h/%b/%0d exp=%h/%b/%0d", n, r_mar, r_op, r_rsp, a, op, r_moc + 3); end
            end else begin
                total++; if (r_rsp != r_acc + 1) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", n, r_rsp, r_acc + 1); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_op3 = 0; bus.req_addr = 0; bus.req_wdata = 0;
        #1;
        for (int i = 0; i < 512; i++) rmem[i] = mem[i];
        test_reset;
        test_word_load;
        test_signed_byte;
        test_errors;
        test_timeout;
        test_timeout_boundary;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
